// File: rtl/exe_mem_req_pkg.sv
// ---------------------------------------------------------------------------
// exe_mem_req_pkg
// Shared definitions for the execute-stage memory request unit and its lane
// helper: access size encodings, request FSM state codes, and the bit index
// of the alignment exception (ALE) in the exception number vector.
// The helper align_lo() forces the low address bits to the natural alignment
// of an access size. It is used when alignment checking is compiled out
// (EXE_MEM_ALE_CHECK_EN undefined).
// ---------------------------------------------------------------------------
package exe_mem_req_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    // ALE ecode position in the exception vector carried down the pipeline.
    localparam int EXC_ALE_BIT = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            MEM_SIZE_B: align_lo = lo;
            MEM_SIZE_H: align_lo = {lo[1], 1'b0};
            default:    align_lo = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/exe_mem_req_if.sv
// ---------------------------------------------------------------------------
// exe_mem_req_if
// Data-side bus between the EXE memory request unit (master) and the bus
// bridge (slave).
//   data_req/data_wr/data_size/data_addr/data_wstrb/data_wdata : request
//   data_addr_ok : request accepted this cycle
//   data_data_ok : one response returned this cycle (in request order)
// Handshake: a request transfers on a cycle where data_req and data_addr_ok
// are both high. Once data_req rises, it and all request fields hold steady
// until that transfer. data_data_ok needs no ready; the master always takes
// it.
// ---------------------------------------------------------------------------
interface exe_mem_req_if #(parameter int ADDR_W = 32);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok
    );
endinterface

// File: rtl/exe_mem_lane.sv
// ---------------------------------------------------------------------------
// exe_mem_lane
// Combinational byte-lane generator.
//   wr, size, addr_lo, wdata_in -> wstrb (0 for loads), wdata_out
//   (byte x4 / half x2 / word as-is), ale.
// Macro EXE_MEM_ALE_CHECK_EN: when defined, ale flags misaligned half/word
// accesses; when undefined, ale is tied to 0.
// ---------------------------------------------------------------------------
module exe_mem_lane
    import exe_mem_req_pkg::*;
(
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_out,
    output logic        ale
);

    logic ale_raw;

    always_comb begin
        wstrb     = 4'b1111;
        wdata_out = wdata_in;
        ale_raw   = 1'b0;
        case (size)
            MEM_SIZE_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
            end
            MEM_SIZE_H: begin
                wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_out = {2{wdata_in[15:0]}};
                ale_raw   = addr_lo[0];
            end
            default: begin
                ale_raw = (addr_lo != 2'b00);
            end
        endcase
        if (!wr) wstrb = 4'b0000;
    end

`ifdef EXE_MEM_ALE_CHECK_EN
    assign ale = ale_raw;
`else
    // The raw flag is still computed above but unused, so the address
    // decode stays identical in both builds.
    logic unused_ale;
    assign unused_ale = ale_raw;
    assign ale        = 1'b0;
`endif

endmodule

// File: rtl/exe_mem_req.sv
// ---------------------------------------------------------------------------
// exe_mem_req
// Execute-stage memory request unit. It issues load/store requests over a
// req/addr_ok/data_ok bus, tracks outstanding requests, and marks responses
// of flushed instructions for discard.
// Ports:
//   clk, reset (sync, active-high)
//   op_valid/op_wr/op_size/op_addr/op_wdata : current EXE memory op
//   block_store : suppress store issue; es_advance : EXE hands op to MEM
//   flush : kill all in-flight instructions
//   op_ready : memory part of es_ready_go; ale : alignment exception
//   bus (exe_mem_req_if.master) : data-side request/response bus
//   resp_discard : current data_ok belongs to a flushed instruction
//   outst_cnt/outst_full : accepted-but-unanswered requests
//   state_dbg : FSM state
// Macro EXE_MEM_ALE_CHECK_EN: defined -> misaligned ops raise ale and issue
// nothing. Undefined -> ale is 0 and the issued address is forced aligned.
// ---------------------------------------------------------------------------
module exe_mem_req
    import exe_mem_req_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int OUTST_DEPTH = 2,
    parameter int CNT_W       = $clog2(OUTST_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_wr,
    input  logic [1:0]        op_size,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_wdata,
    input  logic              block_store,
    input  logic              es_advance,
    input  logic              flush,
    output logic              op_ready,
    output logic              ale,
    exe_mem_req_if.master     bus,
    output logic              resp_discard,
    output logic [CNT_W-1:0]  outst_cnt,
    output logic              outst_full,
    output mem_state_t        state_dbg
);

    mem_state_t        state;
    logic              pend_cancel;
    logic [CNT_W-1:0]  cancel_cnt;
    logic              lat_wr;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [3:0]        lat_wstrb;
    logic [31:0]       lat_wdata;

    logic [3:0]        lane_wstrb;
    logic [31:0]       lane_wdata;
    logic [ADDR_W-1:0] issue_addr;
    logic              need_req;
    logic              data_req;
    logic              accept;
    logic [CNT_W-1:0]  outst_next;
    logic [CNT_W-1:0]  cancel_next;

    exe_mem_lane u_lane (
        .wr        (op_wr),
        .size      (op_size),
        .addr_lo   (op_addr[1:0]),
        .wdata_in  (op_wdata),
        .wstrb     (lane_wstrb),
        .wdata_out (lane_wdata),
        .ale       (ale)
    );

`ifdef EXE_MEM_ALE_CHECK_EN
    assign issue_addr = op_addr;
`else
    assign issue_addr = {op_addr[ADDR_W-1:2], align_lo(op_size, op_addr[1:0])};
`endif

    // ALE ops and blocked stores pass through EXE as non-memory ops.
    assign need_req   = op_valid & ~ale & ~(op_wr & block_store);
    // Reset removes the request in the same cycle; the bridge is reset too.
    assign data_req   = (state == ST_REQ) & ~reset;
    assign accept     = data_req & bus.data_addr_ok;
    assign outst_full = (outst_cnt == CNT_W'(OUTST_DEPTH));
    assign resp_discard = bus.data_data_ok & (cancel_cnt != '0);

    always_comb begin
        op_ready = 1'b0;
        case (state)
            ST_IDLE: op_ready = op_valid & ~need_req;
            ST_REQ:  op_ready = bus.data_addr_ok & ~pend_cancel;
            ST_DONE: op_ready = 1'b1;
            default: op_ready = 1'b0;
        endcase
    end

    always_comb begin
        outst_next = outst_cnt;
        if (accept && !bus.data_data_ok)
            outst_next = outst_cnt + CNT_W'(1);
        else if (!accept && bus.data_data_ok)
            outst_next = outst_cnt - CNT_W'(1);
    end

    // On flush, every request still owed a response is killed. That count
    // already includes this cycle's accept and excludes this cycle's
    // response. A request accepted after a flush taken in REQ is added late.
    always_comb begin
        cancel_next = cancel_cnt;
        if (flush) begin
            cancel_next = outst_next;
        end else begin
            if (accept && pend_cancel) cancel_next = cancel_next + CNT_W'(1);
            if (resp_discard)          cancel_next = cancel_next - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outst_cnt  <= '0;
            cancel_cnt <= '0;
        end else begin
            outst_cnt  <= outst_next;
            cancel_cnt <= cancel_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pend_cancel <= 1'b0;
            lat_wr      <= 1'b0;
            lat_size    <= 2'b00;
            lat_addr    <= '0;
            lat_wstrb   <= 4'b0000;
            lat_wdata   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (need_req && !flush && !outst_full) begin
                        state     <= ST_REQ;
                        lat_wr    <= op_wr;
                        lat_size  <= op_size;
                        lat_addr  <= issue_addr;
                        lat_wstrb <= lane_wstrb;
                        lat_wdata <= lane_wdata;
                    end
                end
                ST_REQ: begin
                    // The request is never withdrawn. A flush only marks it
                    // so its response is discarded after acceptance.
                    if (bus.data_addr_ok) begin
                        pend_cancel <= 1'b0;
                        if (pend_cancel || flush || es_advance) state <= ST_IDLE;
                        else                                    state <= ST_DONE;
                    end else if (flush) begin
                        pend_cancel <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Hold here while MEM stalls so the op is not reissued.
                    if (es_advance || flush) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_req   = data_req;
    assign bus.data_wr    = lat_wr;
    assign bus.data_size  = lat_size;
    assign bus.data_addr  = lat_addr;
    assign bus.data_wstrb = lat_wstrb;
    assign bus.data_wdata = lat_wdata;
    assign state_dbg      = state;

endmodule

// File: tb/tb_exe_mem_req.sv
// ---------------------------------------------------------------------------
// tb_exe_mem_req
// Directed bench for exe_mem_req (ADDR_W=32, OUTST_DEPTH=2). Inputs change
// 1 ns after each rising edge. Outputs are checked 1 ns later, well before
// the next edge.
// ---------------------------------------------------------------------------
module tb_exe_mem_req;
    import exe_mem_req_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_wr, block_store, es_advance, flush;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        op_ready, ale, resp_discard, outst_full;
    logic [1:0]  outst_cnt;
    mem_state_t  state_dbg;

    int checks   = 0;
    int failures = 0;

    exe_mem_req_if #(.ADDR_W(32)) bus ();

    exe_mem_req #(.ADDR_W(32), .OUTST_DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_wr        (op_wr),
        .op_size      (op_size),
        .op_addr      (op_addr),
        .op_wdata     (op_wdata),
        .block_store  (block_store),
        .es_advance   (es_advance),
        .flush        (flush),
        .op_ready     (op_ready),
        .ale          (ale),
        .bus          (bus.master),
        .resp_discard (resp_discard),
        .outst_cnt    (outst_cnt),
        .outst_full   (outst_full),
        .state_dbg    (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        op_valid = v;
        op_wr    = wr;
        op_size  = sz;
        op_addr  = a;
        op_wdata = d;
    endtask

    initial begin
        reset = 1'b1;
        set_op(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        block_store      = 1'b0;
        es_advance       = 1'b1;
        flush            = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        chk("rst_state", state_dbg, ST_IDLE);
        chk("rst_req", bus.data_req, 1'b0);
        chk("rst_outst", outst_cnt, 2'd0);
        chk("rst_discard", resp_discard, 1'b0);
        chk("rst_cancel", dut.cancel_cnt, 2'd0);
        chk("rst_pend", dut.pend_cancel, 1'b0);
        chk("rst_addr", bus.data_addr, 32'h0);
        reset = 1'b0;
        settle();

        // ---------------- 1: st.w, addr_ok after 3 cycles ----------------
        set_op(1'b1, 1'b1, MEM_SIZE_W, 32'h1C00_0100, 32'hDEAD_BEEF);
        settle();
        chk("t1_ready_idle", op_ready, 1'b0);
        tick();
        chk("t1_req_c1", bus.data_req, 1'b1);
        chk("t1_wstrb", bus.data_wstrb, 4'hF);
        chk("t1_wdata", bus.data_wdata, 32'hDEAD_BEEF);
        chk("t1_addr", bus.data_addr, 32'h1C00_0100);
        chk("t1_wr", bus.data_wr, 1'b1);
        chk("t1_ready_c1", op_ready, 1'b0);
        tick();
        chk("t1_req_c2", bus.data_req, 1'b1);
        tick();
        bus.data_addr_ok = 1'b1;
        settle();
        chk("t1_req_c3", bus.data_req, 1'b1);
        chk("t1_ready_aok", op_ready, 1'b1);
        tick();
        bus.data_addr_ok = 1'b0;
        op_valid = 1'b0;
        settle();
        chk("t1_state", state_dbg, ST_IDLE);
        chk("t1_req_off", bus.data_req, 1'b0);
        chk("t1_outst1", outst_cnt, 2'd1);
        bus.data_data_ok = 1'b1;
        settle();
        chk("t1_nodiscard", resp_discard, 1'b0);
        tick();
        bus.data_data_ok = 1'b0;
        chk("t1_outst0", outst_cnt, 2'd0);

        // ---------------- 2: st.b / st.h lanes, ld.h misaligned ----------------
        set_op(1'b1, 1'b1, MEM_SIZE_B, 32'h1C00_0103, 32'h0000_00A5);
        tick();
        chk("t2b_wstrb", bus.data_wstrb, 4'b1000);
        chk("t2b_wdata", bus.data_wdata, 32'hA5A5_A5A5);
        chk("t2b_size", bus.data_size, MEM_SIZE_B);
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        set_op(1'b1, 1'b1, MEM_SIZE_H, 32'h1C00_0102, 32'h0000_1234);
        tick();
        chk("t2h_wstrb", bus.data_wstrb, 4'b1100);
        chk("t2h_wdata", bus.data_wdata, 32'h1234_1234);
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        op_valid = 1'b0;
        chk("t2_outst2", outst_cnt, 2'd2);
        bus.data_data_ok = 1'b1;
        tick();
        tick();
        bus.data_data_ok = 1'b0;
        chk("t2_outst0", outst_cnt, 2'd0);

        set_op(1'b1, 1'b0, MEM_SIZE_H, 32'h1C00_0101, 32'h0);
        settle();
`ifdef EXE_MEM_ALE_CHECK_EN
        chk("t2_ale", ale, 1'b1);
        chk("t2_ale_ready", op_ready, 1'b1);
        tick();
        chk("t2_ale_noreq", bus.data_req, 1'b0);
        op_valid = 1'b0;
`else
        chk("t2_ale", ale, 1'b0);
        chk("t2_ale_ready", op_ready, 1'b0);
        tick();
        chk("t2_lh_req", bus.data_req, 1'b1);
        chk("t2_lh_addr", bus.data_addr, 32'h1C00_0100);
        chk("t2_lh_wstrb", bus.data_wstrb, 4'b0000);
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        op_valid = 1'b0;
        bus.data_data_ok = 1'b1;
        tick();
        bus.data_data_ok = 1'b0;
        chk("t2_lh_outst0", outst_cnt, 2'd0);
`endif

        // ---------------- 3: outstanding limit ----------------
        set_op(1'b1, 1'b0, MEM_SIZE_W, 32'h1C00_0200, 32'h0);
        tick();
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        op_addr = 32'h1C00_0204;
        tick();
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        op_addr = 32'h1C00_0208;
        settle();
        chk("t3_outst2", outst_cnt, 2'd2);
        chk("t3_full", outst_full, 1'b1);
        chk("t3_ready_full", op_ready, 1'b0);
        tick();
        chk("t3_hold1", state_dbg, ST_IDLE);
        tick();
        chk("t3_hold2", bus.data_req, 1'b0);
        bus.data_data_ok = 1'b1;
        tick();
        bus.data_data_ok = 1'b0;
        chk("t3_after_dok", state_dbg, ST_IDLE);
        chk("t3_notfull", outst_full, 1'b0);
        tick();
        chk("t3_issue", bus.data_req, 1'b1);
        chk("t3_addr", bus.data_addr, 32'h1C00_0208);
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        op_valid = 1'b0;
        bus.data_data_ok = 1'b1;
        tick();
        tick();
        bus.data_data_ok = 1'b0;
        chk("t3_drain", outst_cnt, 2'd0);

        // ---------------- 4: flush in REQ with one older outstanding ----------------
        set_op(1'b1, 1'b0, MEM_SIZE_W, 32'h1C00_0300, 32'h0);
        tick();
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        op_addr = 32'h1C00_0304;
        tick();
        flush    = 1'b1;
        op_valid = 1'b0;
        settle();
        chk("t4_ready_flush", op_ready, 1'b0);
        tick();
        flush = 1'b0;
        chk("t4_still_req", bus.data_req, 1'b1);
        chk("t4_pend", dut.pend_cancel, 1'b1);
        chk("t4_cancel1", dut.cancel_cnt, 2'd1);
        tick();
        bus.data_addr_ok = 1'b1;
        settle();
        chk("t4_ready_cancel", op_ready, 1'b0);
        tick();
        bus.data_addr_ok = 1'b0;
        chk("t4_idle", state_dbg, ST_IDLE);
        chk("t4_cancel2", dut.cancel_cnt, 2'd2);
        chk("t4_outst2", outst_cnt, 2'd2);
        chk("t4_pend_clr", dut.pend_cancel, 1'b0);
        bus.data_data_ok = 1'b1;
        settle();
        chk("t4_disc1", resp_discard, 1'b1);
        tick();
        chk("t4_disc2", resp_discard, 1'b1);
        tick();
        bus.data_data_ok = 1'b0;
        settle();
        chk("t4_cancel0", dut.cancel_cnt, 2'd0);
        chk("t4_nodisc", resp_discard, 1'b0);

        // ---------------- 5: MEM stall holds DONE, single issue ----------------
        set_op(1'b1, 1'b0, MEM_SIZE_W, 32'h1C00_0400, 32'h0);
        es_advance = 1'b0;
        tick();
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        chk("t5_done", state_dbg, ST_DONE);
        for (int i = 0; i < 4; i++) begin
            chk("t5_stall_noreq", bus.data_req, 1'b0);
            chk("t5_stall_ready", op_ready, 1'b1);
            tick();
        end
        es_advance = 1'b1;
        tick();
        op_valid = 1'b0;
        chk("t5_back_idle", state_dbg, ST_IDLE);
        chk("t5_one_req", outst_cnt, 2'd1);
        // flush with data_ok while nothing is cancelled: response is kept
        flush = 1'b1;
        bus.data_data_ok = 1'b1;
        settle();
        chk("t5_flush_dok_keep", resp_discard, 1'b0);
        tick();
        flush = 1'b0;
        bus.data_data_ok = 1'b0;
        chk("t5_cancel0", dut.cancel_cnt, 2'd0);
        chk("t5_outst0", outst_cnt, 2'd0);

        // ---------------- 6: block_store ----------------
        block_store = 1'b1;
        set_op(1'b1, 1'b1, MEM_SIZE_W, 32'h1C00_0500, 32'h1111_2222);
        settle();
        chk("t6_st_ready", op_ready, 1'b1);
        tick();
        chk("t6_st_noreq", bus.data_req, 1'b0);
        op_wr = 1'b0;
        settle();
        chk("t6_ld_ready", op_ready, 1'b0);
        tick();
        chk("t6_ld_req", bus.data_req, 1'b1);
        chk("t6_ld_wstrb", bus.data_wstrb, 4'b0000);
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        op_valid    = 1'b0;
        block_store = 1'b0;
        bus.data_data_ok = 1'b1;
        tick();
        bus.data_data_ok = 1'b0;
        chk("t6_outst0", outst_cnt, 2'd0);

        // ---------------- reset while in REQ ----------------
        set_op(1'b1, 1'b0, MEM_SIZE_W, 32'h1C00_0600, 32'h0);
        tick();
        chk("rr_req", bus.data_req, 1'b1);
        reset = 1'b1;
        settle();
        chk("rr_req_drop", bus.data_req, 1'b0);
        tick();
        reset    = 1'b0;
        op_valid = 1'b0;
        chk("rr_idle", state_dbg, ST_IDLE);
        chk("rr_addr_clr", bus.data_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
